// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and data (MA) with round-robin grant; done pulses 2 cycles after grant at best.
// Requesters are held off via stall_* until their done pulse; a hung access is aborted after TIMEOUT_CYCLES waits.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic [1:0]  ma_read,
  input  logic [1:0]  ma_write,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_wdata,
  output logic [31:0] ma_rdata,
  output logic        ma_done,
  output logic        stall_if,
  output logic        stall_ma,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        timeout_err
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_ma_q, last_ma_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        terr_q, terr_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] ma_rdata_q, ma_rdata_d;
  logic        if_done_q, if_done_d;
  logic        ma_done_q, ma_done_d;

  logic        ma_pend;
  logic        ma_is_wr;
  logic        pick_ma;
  logic [7:0]  cnt_inc;
  logic [31:0] rd_val;

  assign ma_pend  = (ma_read != 2'b00) || (ma_write != 2'b00);
  assign ma_is_wr = (ma_write != 2'b00);
  // last_ma_q doubles as "currently granted" while an access is in flight
  assign pick_ma  = ma_pend && (!if_req || !last_ma_q);
  assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    last_ma_d  = last_ma_q;
    cnt_d      = cnt_q;
    terr_d     = terr_q;
    req_d      = req_q;
    we_d       = we_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    ma_rdata_d = ma_rdata_q;
    if_done_d  = if_done_q;
    ma_done_d  = ma_done_q;
    rd_val     = 32'h0;

    unique case (state_q)
      IDLE: begin
        if (if_req || ma_pend) begin
          state_d   = BUSY;
          req_d     = 1'b1;
          cnt_d     = 8'h00;
          last_ma_d = pick_ma;
          if (pick_ma) begin
            we_d    = ma_is_wr;
            size_d  = ma_is_wr ? ma_write : ma_read;
            addr_d  = ma_addr;
            wdata_d = ma_wdata;
          end else begin
            we_d    = 1'b0;
            size_d  = 2'b11;
            addr_d  = if_addr;
            wdata_d = 32'h0;
          end
        end
      end
      BUSY: begin
        // mem_ready wins over a timeout landing on the same cycle
        if (mem_ready || (cnt_inc == TMO)) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (mem_ready && !we_q) begin
            rd_val = mem_rdata;
          end
          if (!mem_ready) begin
            terr_d = 1'b1;
            cnt_d  = cnt_inc;
          end
          if (last_ma_q) begin
            ma_done_d  = 1'b1;
            ma_rdata_d = rd_val;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = rd_val;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        state_d   = IDLE;
        if_done_d = 1'b0;
        ma_done_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_ma_q  <= 1'b0;
      cnt_q      <= 8'h00;
      terr_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      if_rdata_q <= 32'h0;
      ma_rdata_q <= 32'h0;
      if_done_q  <= 1'b0;
      ma_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_ma_q  <= last_ma_d;
      cnt_q      <= cnt_d;
      terr_q     <= terr_d;
      req_q      <= req_d;
      we_q       <= we_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      ma_rdata_q <= ma_rdata_d;
      if_done_q  <= if_done_d;
      ma_done_q  <= ma_done_d;
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_done     = if_done_q;
  assign ma_rdata    = ma_rdata_q;
  assign ma_done     = ma_done_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_size    = size_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign timeout_err = terr_q;
  assign stall_if    = if_req && !if_done_q;
  assign stall_ma    = ma_pend && !ma_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model and per-cycle compare.
module tb_mem_port_arbiter;

  localparam int TMO  = 4;
  localparam int NONE = 0;
  localparam int IFP  = 1;
  localparam int MAP  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic [1:0]  ma_read = 2'b00;
  logic [1:0]  ma_write = 2'b00;
  logic [31:0] ma_addr = 32'h0;
  logic [31:0] ma_wdata = 32'h0;
  logic [31:0] ma_rdata;
  logic        ma_done;
  logic        stall_if;
  logic        stall_ma;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic        timeout_err;

  int total = 0;
  int bad = 0;

  int ready_delay = 0;
  bit ready_noise = 1'b0;
  int busy_cyc = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ma_read(ma_read), .ma_write(ma_write), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .ma_rdata(ma_rdata), .ma_done(ma_done),
    .stall_if(stall_if), .stall_ma(stall_ma),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return a * 32'd3 + 32'h1111;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Memory responder: ready after ready_delay wait cycles (negative = never)
  always @(negedge clk) begin
    if (mem_req) begin
      busy_cyc++;
      mem_ready = (ready_delay >= 0) && (busy_cyc == ready_delay + 1);
    end else begin
      busy_cyc  = 0;
      mem_ready = ready_noise;
    end
    mem_rdata = memword(mem_addr);
  end

  // Reference model: who owns the port, how long it has waited, and what each side should see
  int          m_owner = NONE;
  bit          m_last_ma = 1'b0;
  int          m_wait = 0;
  bit          m_cool = 1'b0;
  bit          m_clean = 1'b0;
  bit          m_valid = 1'b0;
  bit          want_if, want_ma;
  logic        e_req = 1'b0, e_we = 1'b0;
  logic [1:0]  e_size = 2'b00;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0;
  logic [31:0] e_if_rdata = 32'h0, e_ma_rdata = 32'h0;
  logic        e_if_done = 1'b0, e_ma_done = 1'b0, e_terr = 1'b0;

  task finish_access(input logic [31:0] d);
    e_req  = 1'b0;
    m_cool = 1'b1;
    if (m_owner == MAP) begin
      e_ma_done  = 1'b1;
      e_ma_rdata = d;
    end else begin
      e_if_done  = 1'b1;
      e_if_rdata = d;
    end
    m_owner = NONE;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1; m_owner = NONE; m_last_ma = 1'b0; m_wait = 0; m_cool = 1'b0; m_clean = 1'b1;
      e_req = 1'b0; e_we = 1'b0; e_size = 2'b00; e_addr = 32'h0; e_wdata = 32'h0;
      e_if_rdata = 32'h0; e_ma_rdata = 32'h0; e_if_done = 1'b0; e_ma_done = 1'b0; e_terr = 1'b0;
    end else if (m_cool) begin
      m_cool = 1'b0;
      e_if_done = 1'b0;
      e_ma_done = 1'b0;
    end else if (m_owner != NONE) begin
      if (mem_ready) begin
        finish_access(e_we ? 32'h0 : memword(e_addr));
      end else begin
        m_wait++;
        if (m_wait >= TMO) begin
          finish_access(32'h0);
          e_terr = 1'b1;
        end
      end
    end else begin
      want_if = if_req;
      want_ma = (ma_read != 2'b00) || (ma_write != 2'b00);
      if (want_if || want_ma) begin
        if (want_if && want_ma) m_owner = m_last_ma ? IFP : MAP;
        else                    m_owner = want_ma ? MAP : IFP;
        m_last_ma = (m_owner == MAP);
        m_wait = 0;
        m_clean = 1'b0;
        e_req = 1'b1;
        if (m_owner == MAP) begin
          e_we    = (ma_write != 2'b00);
          e_size  = e_we ? ma_write : ma_read;
          e_addr  = ma_addr;
          e_wdata = ma_wdata;
        end else begin
          e_we   = 1'b0;
          e_size = 2'b11;
          e_addr = if_addr;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      chk("mem_req", mem_req, e_req);
      chk("timeout_err", timeout_err, e_terr);
      chk("if_done", if_done, e_if_done);
      chk("ma_done", ma_done, e_ma_done);
      chk("stall_if", stall_if, if_req && !e_if_done);
      chk("stall_ma", stall_ma, ((ma_read != 2'b00) || (ma_write != 2'b00)) && !e_ma_done);
      if (e_req || m_clean) begin
        chk("mem_we", mem_we, e_we);
        chk("mem_size", mem_size, e_size);
        chk("mem_addr", mem_addr, e_addr);
      end
      if ((e_req && e_we) || m_clean) chk("mem_wdata", mem_wdata, e_wdata);
      if (e_if_done || m_clean) chk("if_rdata", if_rdata, e_if_rdata);
      if (e_ma_done || m_clean) chk("ma_rdata", ma_rdata, e_ma_rdata);
    end
  end

  task automatic wait_done(input bit for_ma, input int budget, output int n);
    logic got;
    n = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(negedge clk);
      n++;
      got = for_ma ? ma_done : if_done;
    end
    if (!got) chk(for_ma ? "ma_done_bound" : "if_done_bound", {31'b0, got}, 32'h1);
  endtask

  int n;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 32'h0);
    chk("rst_terr", timeout_err, 32'h0);
    chk("rst_mem_size", mem_size, 32'h0);

    // tie right after reset: MA first, IF stalls throughout
    reset = 1'b0; ready_delay = 1;
    if_req = 1'b1; if_addr = 32'h200; ma_read = 2'b11; ma_addr = 32'h2000;
    @(negedge clk);
    chk("tie_first_addr", mem_addr, 32'h2000);
    chk("tie_stall_if_b1", stall_if, 32'h1);
    wait_done(1'b1, 20, n);
    chk("tie_ma_lat", n, 32'd2);
    chk("tie_ma_rdata", ma_rdata, 32'h7111);
    chk("tie_stall_if_done", stall_if, 32'h1);
    ma_read = 2'b00;
    @(negedge clk);
    chk("no_grant_in_done", mem_req, 32'h0);
    @(negedge clk);
    chk("tie_if_addr", mem_addr, 32'h200);
    wait_done(1'b0, 20, n);
    chk("tie_if_rdata", if_rdata, 32'h1711);
    if_req = 1'b0;
    @(negedge clk);

    // single fetch with ready on the first BUSY cycle
    ready_delay = 0; if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    chk("fetch_size", mem_size, 32'h3);
    chk("fetch_we", mem_we, 32'h0);
    @(negedge clk);
    chk("fetch_done", if_done, 32'h1);
    chk("fetch_rdata", if_rdata, 32'h00500093);
    if_req = 1'b0;
    @(negedge clk);

    // read and write together: write wins
    ma_read = 2'b01; ma_write = 2'b10; ma_addr = 32'h3000; ma_wdata = 32'hABCD;
    @(negedge clk);
    chk("wr_we", mem_we, 32'h1);
    chk("wr_size", mem_size, 32'h2);
    chk("wr_wdata", mem_wdata, 32'hABCD);
    @(negedge clk);
    chk("wr_done", ma_done, 32'h1);
    chk("wr_rdata", ma_rdata, 32'h0);
    ma_read = 2'b00; ma_write = 2'b00;
    @(negedge clk);

    // second tie after MA was served: IF wins
    if_req = 1'b1; if_addr = 32'h400; ma_read = 2'b10; ma_addr = 32'h500;
    @(negedge clk);
    chk("rr_if_addr", mem_addr, 32'h400);
    chk("rr_stall_ma", stall_ma, 32'h1);
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rr_ma_addr", mem_addr, 32'h500);
    @(negedge clk);
    chk("rr_ma_rdata", ma_rdata, 32'h2011);
    ma_read = 2'b00;
    @(negedge clk);

    // MA request withdrawn before grant; stray mem_ready while idle
    ready_delay = 3; if_req = 1'b1; if_addr = 32'h900;
    @(negedge clk);
    ma_write = 2'b01; ma_addr = 32'hA00;
    @(negedge clk);
    chk("wd_stall_ma", stall_ma, 32'h1);
    @(negedge clk);
    ma_write = 2'b00;
    wait_done(1'b0, 20, n);
    if_req = 1'b0; ready_noise = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wd_dropped", mem_req, 32'h0);
    end
    ready_noise = 1'b0;

    // ready arrives on the cycle the counter hits the limit: normal completion
    ready_delay = 3; ma_read = 2'b11; ma_addr = 32'hB00;
    wait_done(1'b1, 20, n);
    chk("bnd_lat", n, 32'd5);
    chk("bnd_rdata", ma_rdata, 32'h3211);
    chk("bnd_terr", timeout_err, 32'h0);
    ma_read = 2'b00;
    @(negedge clk);

    // hung access is aborted after TMO waits; error stays sticky
    ready_delay = -1; ma_read = 2'b11; ma_addr = 32'hC00;
    wait_done(1'b1, 20, n);
    chk("to_lat", n, 32'd5);
    chk("to_rdata", ma_rdata, 32'h0);
    chk("to_terr", timeout_err, 32'h1);
    ma_read = 2'b00;
    @(negedge clk);
    ready_delay = 0; if_req = 1'b1; if_addr = 32'h100;
    wait_done(1'b0, 20, n);
    chk("to_next_rdata", if_rdata, 32'h00500093);
    chk("to_sticky", timeout_err, 32'h1);
    if_req = 1'b0;
    @(negedge clk);

    // reset in the second BUSY cycle
    ready_delay = -1; if_req = 1'b1; if_addr = 32'h700;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_mem_req", mem_req, 32'h0);
    chk("mrst_if_done", if_done, 32'h0);
    chk("mrst_terr", timeout_err, 32'h0);
    chk("mrst_mem_addr", mem_addr, 32'h0);
    chk("mrst_if_rdata", if_rdata, 32'h0);
    reset = 1'b0; ready_delay = 0; if_addr = 32'h800;
    wait_done(1'b0, 20, n);
    chk("mrst_lat", n, 32'd2);
    chk("mrst_rdata", if_rdata, 32'h2911);
    if_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
